// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
//
// Contents:
//   tag_entry_t      one tracking-table entry {valid, owner channel}
//   arb_req_t        request payload {addr, write, size, data, strb} at default widths
//   lowest_free_idx  index of the lowest clear bit of a busy mask
package mem_arb_pkg;

    localparam int MAX_CH     = 8;
    localparam int MAX_TAGS   = 16;
    localparam int OWNER_W    = 3;
    localparam int TAG_IDX_W  = 4;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_entry_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [ARB_DATA_W-1:0] data;
        logic [ARB_STRB_W-1:0] strb;
    } arb_req_t;

    // Unimplemented table slots are passed in as busy so they are never chosen.
    function automatic logic [TAG_IDX_W-1:0] lowest_free_idx(input logic [MAX_TAGS-1:0] busy);
        logic [TAG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx = TAG_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - downstream request/response port of the memory arbiter
//
// master: arbiter side (drives req_*, rsp_ready; receives req_ready, rsp_*)
// slave : memory/adapter side
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [2:0]            req_size;
    logic [DATA_WIDTH-1:0] req_data;
    logic [STRB_W-1:0]     req_strb;
    logic [ID_WIDTH-1:0]   req_id;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;
    logic [ID_WIDTH-1:0]   rsp_id;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_data, req_strb, req_id,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_error, rsp_id,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_data, req_strb, req_id,
        output req_ready,
        output rsp_valid, rsp_data, rsp_error, rsp_id,
        input  rsp_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way request arbiter, round-robin or fixed priority
//
// Ports: clk_i, rst_i (sync, active-high); req [N] requests; advance = the
// current grant was taken this cycle; grant [N] one-hot, combinational from req.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest)
// and removes the last_grant pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN

    always_comb begin
        grant = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
            end
        end
    end

`else

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] last_q;
    logic             found;

    // Search starts one past the last winner; reset to N-1 so channel 0 wins first.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(last_q) + k) % N)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PTR_W'(N - 1);
        end else if (advance) begin
            for (int j = 0; j < N; j++) begin
                if (grant[j]) begin
                    last_q <= PTR_W'(j);
                end
            end
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-channel request arbiter with ID tagging and response routing
//
// Ports: clk_i, rst_i (sync, active-high); ch_req_* per-channel requests;
// ch_rsp_* per-channel responses; m (mem_port_arbiter_if.master) downstream
// port; outstanding_o allocated tag count; unexp_rsp_o sticky unknown-ID flag.
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin,
// selected inside rr_arbiter).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CH          = 2,
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int ID_WIDTH        = 4,
    localparam int STRB_W          = DATA_WIDTH / 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_CH-1:0]                    ch_req_valid_i,
    output logic [NUM_CH-1:0]                    ch_req_ready_o,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    ch_req_addr_i,
    input  logic [NUM_CH-1:0]                    ch_req_write_i,
    input  logic [NUM_CH-1:0][2:0]               ch_req_size_i,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_req_data_i,
    input  logic [NUM_CH-1:0][STRB_W-1:0]        ch_req_strb_i,
    output logic [NUM_CH-1:0]                    ch_rsp_valid_o,
    input  logic [NUM_CH-1:0]                    ch_rsp_ready_i,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_rsp_data_o,
    output logic [NUM_CH-1:0]                    ch_rsp_error_o,
    mem_port_arbiter_if.master                   m,
    output logic [CNT_W-1:0]                     outstanding_o,
    output logic                                 unexp_rsp_o
);

    if ((2 ** ID_WIDTH) < MAX_OUTSTANDING) begin : g_id_width_check
        $error("mem_port_arbiter: ID_WIDTH too small for MAX_OUTSTANDING");
    end
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_num_ch_check
        $error("mem_port_arbiter: NUM_CH must be 1..8");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_TAGS) begin : g_max_out_check
        $error("mem_port_arbiter: MAX_OUTSTANDING must be 1..16");
    end

    tag_entry_t              table_q [MAX_OUTSTANDING];
    logic [MAX_TAGS-1:0]     busy;
    logic [TAG_IDX_W-1:0]    alloc_idx;
    logic                    tag_free;
    logic                    slot_free;
    logic                    req_fire;
    logic [NUM_CH-1:0]       grant;
    logic [OWNER_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_write;
    logic [2:0]              sel_size;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [STRB_W-1:0]       sel_strb;
    logic                    rsp_hit;
    logic [OWNER_W-1:0]      rsp_owner;
    logic                    owner_ready;
    logic                    rsp_fire;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (ch_req_valid_i),
        .advance (req_fire),
        .grant   (grant)
    );

    always_comb begin
        busy = '1;
        for (int t = 0; t < MAX_OUTSTANDING; t++) begin
            busy[t] = table_q[t].valid;
        end
    end

    assign tag_free  = ~&busy;
    assign alloc_idx = lowest_free_idx(busy);
    assign slot_free = !m.req_valid || m.req_ready;

    // Gated by reset so the channels never see ready from pre-reset state.
    assign ch_req_ready_o = rst_i ? '0 : (grant & {NUM_CH{slot_free & tag_free}});
    assign req_fire       = |(ch_req_valid_i & ch_req_ready_o);

    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                grant_idx = OWNER_W'(c);
                sel_addr  = ch_req_addr_i[c];
                sel_write = ch_req_write_i[c];
                sel_size  = ch_req_size_i[c];
                sel_data  = ch_req_data_i[c];
                sel_strb  = ch_req_strb_i[c];
            end
        end
    end

    // IDs beyond the table or pointing at a free entry never hit.
    always_comb begin
        rsp_hit   = 1'b0;
        rsp_owner = '0;
        for (int t = 0; t < MAX_OUTSTANDING; t++) begin
            if (table_q[t].valid && m.rsp_id == ID_WIDTH'(t)) begin
                rsp_hit   = 1'b1;
                rsp_owner = table_q[t].owner;
            end
        end
    end

    always_comb begin
        owner_ready    = 1'b0;
        ch_rsp_valid_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rsp_owner == OWNER_W'(c)) begin
                owner_ready       = ch_rsp_ready_i[c];
                ch_rsp_valid_o[c] = m.rsp_valid & rsp_hit;
            end
        end
    end

    // Unknown IDs are swallowed so a stray response cannot wedge the port.
    assign m.rsp_ready     = rsp_hit ? owner_ready : 1'b1;
    assign rsp_fire        = m.rsp_valid && m.rsp_ready && rsp_hit;
    assign ch_rsp_data_o   = {NUM_CH{m.rsp_data}};
    assign ch_rsp_error_o  = {NUM_CH{m.rsp_error}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < MAX_OUTSTANDING; t++) begin
                table_q[t] <= '0;
            end
            outstanding_o <= '0;
            unexp_rsp_o   <= 1'b0;
            m.req_valid   <= 1'b0;
            m.req_addr    <= '0;
            m.req_write   <= 1'b0;
            m.req_size    <= '0;
            m.req_data    <= '0;
            m.req_strb    <= '0;
            m.req_id      <= '0;
        end else begin
            // The allocated entry was free at cycle start, so it never collides with the freed one.
            for (int t = 0; t < MAX_OUTSTANDING; t++) begin
                if (req_fire && alloc_idx == TAG_IDX_W'(t)) begin
                    table_q[t] <= '{valid: 1'b1, owner: grant_idx};
                end else if (rsp_fire && m.rsp_id == ID_WIDTH'(t)) begin
                    table_q[t].valid <= 1'b0;
                end
            end

            case ({req_fire, rsp_fire})
                2'b10:   outstanding_o <= outstanding_o + CNT_W'(1);
                2'b01:   outstanding_o <= outstanding_o - CNT_W'(1);
                default: outstanding_o <= outstanding_o;
            endcase

            if (m.rsp_valid && !rsp_hit) begin
                unexp_rsp_o <= 1'b1;
            end

            if (req_fire) begin
                m.req_valid <= 1'b1;
                m.req_addr  <= sel_addr;
                m.req_write <= sel_write;
                m.req_size  <= sel_size;
                m.req_data  <= sel_data;
                m.req_strb  <= sel_strb;
                m.req_id    <= ID_WIDTH'(alloc_idx);
            end else if (m.req_ready) begin
                m.req_valid <= 1'b0;
            end
        end
    end

endmodule
